mix_signature_collector: RTL and testbench

- Downstream consumer of the 8-lane, 32-bit mixing datapath.
- Accepts one full 8-word sample per handshake and folds the lanes serially, one lane per cycle, into a rolling 32-bit signature.
- After a fixed number of samples, pulses done and reports whether the signature equals an externally supplied expected value.
- Serves as the self-checking tail of the compute benchmark.

---
 rtl/mix_sig_pkg.sv | 18 +
 rtl/mix_sig_lane_mux.sv | 33 +++
 rtl/mix_signature_collector.sv | 134 +++++++++++++
 tb/tb_mix_signature_collector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mix_sig_pkg.sv
// Shared types and the signature step for the mix signature collector.
// The step function is the single definition of the fold arithmetic.
package mix_sig_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, FOLD, FINISH} state_t;

  localparam int                SIG_W        = 32;
  localparam logic [SIG_W-1:0]  DEFAULT_SEED = 32'h811C9DC5;
  localparam int                ROT_AMT      = 5;

  // rotl(sig, ROT_AMT) ^ (lane + idx), all modulo 2^SIG_W
  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                input logic [SIG_W-1:0] lane,
                                                input logic [SIG_W-1:0] idx);
    return {sig[SIG_W-ROT_AMT-1:0], sig[SIG_W-1:SIG_W-ROT_AMT]} ^ (lane + idx);
  endfunction

endpackage

// File: rtl/mix_sig_lane_mux.sv
// Holding register for one accepted sample plus the lane selector used by
// the serial fold.
module mix_sig_lane_mux #(
  parameter int WIDTH = 32,
  parameter int LANES = 8,
  parameter int IDX_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic [IDX_W-1:0]         idx,
  output logic [WIDTH-1:0]         lane
);

  logic [LANES*WIDTH-1:0] hold;
  logic [WIDTH-1:0]       words [LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (load) begin
      hold <= in_data;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_words
    assign words[k] = hold[k*WIDTH +: WIDTH];
  end

  assign lane = words[idx];

endmodule

// File: rtl/mix_signature_collector.sv
// Folds 8-lane samples one lane per cycle into a rolling signature and
// compares against a golden value. MIX_SIG_OVERLAP_EN overlaps accept with the last fold.
module mix_signature_collector
  import mix_sig_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               LANES   = 8,
  parameter int               SAMPLES = 1024,
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(DEFAULT_SEED)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*WIDTH-1:0]        in_data,
  input  logic [WIDTH-1:0]              expected,
  output logic                          busy,
  output logic                          done,
  output logic                          match,
  output logic [WIDTH-1:0]              signature,
  output logic [$clog2(SAMPLES+1)-1:0]  sample_cnt
);

  localparam int                IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int                CNT_W    = $clog2(SAMPLES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SAMPLES);
`ifdef MIX_SIG_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   lane;
  logic [WIDTH-1:0]   sig_next;
  logic               accept;
  logic               last_lane;
  logic [CNT_W-1:0]   cnt_inc;
  logic               final_sample;
  logic               final_next;

  assign accept       = in_valid && in_ready;
  assign last_lane    = (idx == LAST_IDX);
  assign cnt_inc      = (sample_cnt == CNT_MAX) ? CNT_MAX : sample_cnt + CNT_W'(1);
  // final_sample: the sample now folding is the last of the run;
  // final_next: a sample accepted during its last fold would be the last.
  assign final_sample = (cnt_inc == CNT_MAX);
  assign final_next   = ((cnt_inc + CNT_W'(1)) == CNT_MAX);

  mix_sig_lane_mux #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_lane_mux (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .in_data (in_data),
    .idx     (idx),
    .lane    (lane)
  );

  if (WIDTH == SIG_W) begin : g_pkg_step
    assign sig_next = sig_step(signature, lane, SIG_W'(idx));
  end else begin : g_generic_step
    assign sig_next = {signature[WIDTH-ROT_AMT-1:0], signature[WIDTH-1:WIDTH-ROT_AMT]}
                      ^ (lane + WIDTH'(idx));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      match      <= 1'b0;
      signature  <= SEED;
      sample_cnt <= '0;
      idx        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            signature  <= SEED;
            sample_cnt <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            idx      <= '0;
            in_ready <= OVERLAP && (LANES == 1) && !final_sample;
            state    <= FOLD;
          end
        end
        FOLD: begin
          signature <= sig_next;
          if (!last_lane) begin
            idx      <= idx + IDX_W'(1);
            // Registered ready must already be high when idx reaches the last lane.
            in_ready <= OVERLAP && ((idx + IDX_W'(1)) == LAST_IDX) && !final_sample;
          end else begin
            sample_cnt <= cnt_inc;
            idx        <= '0;
            if (final_sample) begin
              in_ready <= 1'b0;
              done     <= 1'b1;
              state    <= FINISH;
            end else if (OVERLAP && accept) begin
              in_ready <= OVERLAP && (LANES == 1) && !final_next;
              state    <= FOLD;
            end else begin
              in_ready <= 1'b1;
              state    <= COLLECT;
            end
          end
        end
        FINISH: begin
          match <= (signature == expected);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_signature_collector.sv
// Bench for mix_signature_collector: hand-computed vectors on a 2-lane/1-sample
// instance, plus full-size runs with throughput, reset and start-pulse sequences.
`timescale 1ns/1ps
module tb_mix_signature_collector;
  import mix_sig_pkg::*;

  localparam int          B_LANES   = 8;
  localparam int          B_SAMPLES = 1024;
  localparam int          B_W       = B_LANES * 32;
  localparam logic [31:0] SEED_C    = 32'h811C9DC5;
`ifdef MIX_SIG_OVERLAP_EN
  localparam int          PERIOD    = B_LANES;
`else
  localparam int          PERIOD    = B_LANES + 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_start, s_in_valid, s_in_ready, s_busy, s_done, s_match;
  logic [63:0] s_in_data;
  logic [31:0] s_expected, s_signature;
  logic [0:0]  s_sample_cnt;

  logic           b_start, b_in_valid, b_in_ready, b_busy, b_done, b_match;
  logic [B_W-1:0] b_in_data;
  logic [31:0]    b_expected, b_signature;
  logic [10:0]    b_sample_cnt;

  mix_signature_collector #(.WIDTH(32), .LANES(2), .SAMPLES(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .in_data(s_in_data), .expected(s_expected),
    .busy(s_busy), .done(s_done), .match(s_match), .signature(s_signature),
    .sample_cnt(s_sample_cnt)
  );

  mix_signature_collector u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .expected(b_expected),
    .busy(b_busy), .done(b_done), .match(b_match), .signature(b_signature),
    .sample_cnt(b_sample_cnt)
  );

  typedef struct {
    logic [31:0] l0, l1, expected, sig0, sig1;
    logic        match;
  } vec_t;

  vec_t           vecs [5];
  logic [B_W-1:0] samples [B_SAMPLES];
  logic [31:0]    model;
  logic           prev_match;
  int             errors = 0;
  int             checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_sig();
    logic [31:0] s = SEED_C;
    for (int n = 0; n < B_SAMPLES; n++)
      for (int j = 0; j < B_LANES; j++)
        s = sig_step(s, samples[n][j*32 +: 32], 32'(j));
    return s;
  endfunction

  // One start+accept on the 2-lane instance; in_valid rises together with start.
  task automatic run_small(input int v);
    @(negedge clk);
    s_expected = vecs[v].expected;
    s_in_data  = {vecs[v].l1, vecs[v].l0};
    s_in_valid = 1'b1;
    s_start    = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("s_ready_collect", s_in_ready, 1);
    check("s_sig_seed", s_signature, SEED_C);
    check("s_busy_collect", s_busy, 1);
    check("s_match_kept", s_match, prev_match);
    @(negedge clk);
    s_in_valid = 1'b0;
    s_in_data  = '1;
    check("s_ready_fold", s_in_ready, 0);
    check("s_done_early", s_done, 0);
    @(negedge clk);
    check("s_sig_fold0", s_signature, vecs[v].sig0);
    check("s_done_early2", s_done, 0);
    @(negedge clk);
    check("s_sig_fold1", s_signature, vecs[v].sig1);
    check("s_done_pulse", s_done, 1);
    @(negedge clk);
    check("s_done_low", s_done, 0);
    check("s_match", s_match, vecs[v].match);
    check("s_busy_idle", s_busy, 0);
    check("s_cnt", s_sample_cnt, 1);
    check("s_sig_hold", s_signature, vecs[v].sig1);
    prev_match = vecs[v].match;
  endtask

  // Full run on the default instance with in_valid held high throughout.
  task automatic run_big(input logic [31:0] exp_sig, input bit pulse_starts, input string tag);
    int k = 0, ready_cnt = 0, first_ready = -1, last_ready = -1, bad_gap = 0, done_cyc = 0;
    bit seen_done = 0;
    @(negedge clk);
    b_expected = exp_sig;
    b_in_data  = samples[0];
    b_in_valid = 1'b1;
    b_start    = 1'b1;
    for (int cyc = 0; cyc < B_SAMPLES * (B_LANES + 1) + 50 && !seen_done; cyc++) begin
      @(negedge clk);
      b_start   = pulse_starts && (cyc == 18 || cyc == 22);
      b_in_data = samples[(k < B_SAMPLES) ? k : 0];
      if (b_done) begin
        seen_done = 1;
        done_cyc  = cyc;
        if (pulse_starts) b_start = 1'b1;
      end
      if (b_in_ready) begin
        ready_cnt++;
        if (first_ready < 0) first_ready = cyc;
        else if (cyc - last_ready != PERIOD) bad_gap++;
        last_ready = cyc;
        k++;
      end
    end
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: actual=no done required=done", tag);
    end
    check({tag, "_ready_cnt"}, ready_cnt, B_SAMPLES);
    check({tag, "_ready_gaps"}, bad_gap, 0);
    check({tag, "_span"}, done_cyc - first_ready, PERIOD * (B_SAMPLES - 1) + B_LANES + 1);
    check({tag, "_sig"}, b_signature, exp_sig);
    check({tag, "_cnt"}, b_sample_cnt, B_SAMPLES);
    b_in_valid = 1'b0;
    @(negedge clk);
    b_start = 1'b0;
    check({tag, "_done_low"}, b_done, 0);
    check({tag, "_busy_idle"}, b_busy, 0);
    check({tag, "_match"}, b_match, 1);
    repeat (3) @(negedge clk);
    check({tag, "_sig_hold"}, b_signature, exp_sig);
    check({tag, "_cnt_hold"}, b_sample_cnt, B_SAMPLES);
  endtask

  // Abort a run with reset in the middle of folding the fifth sample.
  task automatic reset_mid();
    int k = 0, done_seen = 0, busy_seen = 0;
    @(negedge clk);
    b_in_data  = samples[0];
    b_in_valid = 1'b1;
    b_start    = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      b_start   = 1'b0;
      if (b_in_ready) k++;
      b_in_data = samples[k];
    end
    check("mid_busy", b_busy, 1);
    check("mid_cnt", b_sample_cnt, 4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", b_in_ready, 0);
    check("mid_rst_busy", b_busy, 0);
    check("mid_rst_done", b_done, 0);
    check("mid_rst_match", b_match, 0);
    check("mid_rst_sig", b_signature, SEED_C);
    check("mid_rst_cnt", b_sample_cnt, 0);
    b_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (b_done) done_seen++;
      if (b_busy) busy_seen++;
    end
    check("mid_no_done", done_seen, 0);
    check("mid_no_busy", busy_seen, 0);
  endtask

  initial begin
    s_start = 0; s_in_valid = 0; s_in_data = '0; s_expected = '0;
    b_start = 0; b_in_valid = 0; b_in_data = '0; b_expected = '0;
    prev_match = 1'b0;

    vecs[0] = '{l0: 32'h0,        l1: 32'h0,        expected: 32'h72771605,
                sig0: 32'h2393B8B0, sig1: 32'h72771605, match: 1'b1};
    vecs[1] = '{l0: 32'h0,        l1: 32'h0,        expected: 32'h72771604,
                sig0: 32'h2393B8B0, sig1: 32'h72771605, match: 1'b0};
    vecs[2] = '{l0: 32'h1,        l1: 32'h0,        expected: 32'h72771625,
                sig0: 32'h2393B8B1, sig1: 32'h72771625, match: 1'b1};
    vecs[3] = '{l0: 32'h0,        l1: 32'hFFFFFFFF, expected: 32'h0,
                sig0: 32'h2393B8B0, sig1: 32'h72771604, match: 1'b0};
    vecs[4] = '{l0: 32'h80000000, l1: 32'h0,        expected: 32'h72771615,
                sig0: 32'hA393B8B0, sig1: 32'h72771615, match: 1'b1};

    for (int n = 0; n < B_SAMPLES; n++)
      for (int j = 0; j < B_LANES; j++)
        samples[n][j*32 +: 32] = $urandom;
    model = model_sig();

    repeat (2) @(negedge clk);
    check("rst_s_ready", s_in_ready, 0);
    check("rst_s_busy", s_busy, 0);
    check("rst_s_done", s_done, 0);
    check("rst_s_match", s_match, 0);
    check("rst_s_sig", s_signature, SEED_C);
    check("rst_s_cnt", s_sample_cnt, 0);
    check("rst_b_ready", b_in_ready, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_sig", b_signature, SEED_C);
    check("rst_b_cnt", b_sample_cnt, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) run_small(v);

    run_big(model, 1'b0, "run1");
    reset_mid();
    run_big(model, 1'b0, "run2");
    run_big(model, 1'b1, "run3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
